// File: rtl/serial_sum_collector_pkg.sv
// Shared definitions for the serial adder collector stage.
//   state_t   : collector FSM states (IDLE, COLLECT, FULL)
//   DEF_WIDTH : default operand/result width
//   cnt_width : bit-counter width able to hold 0..WIDTH
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_sum_outbuf.sv
// One-deep valid/ready output register for the collector.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture load_sum/load_cout (and load_ovf) this edge
//   load_sum/cout     : word to present
//   load_ovf          : overflow flag to present (SERIAL_SUM_OVF_EN only)
//   ready             : consumer takes the held word this edge
//   valid/sum/cout    : presented word
//   ovf               : presented overflow flag (SERIAL_SUM_OVF_EN only)
// Handshake: a word transfers on a rising edge where valid && ready. While
// valid && !ready the data holds still. A load in the same edge as a transfer
// wins, so valid stays high with no bubble.
module serial_sum_outbuf
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_sum,
  input  logic             load_cout,
`ifdef SERIAL_SUM_OVF_EN
  input  logic             load_ovf,
  output logic             ovf,
`endif
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_SUM_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      valid <= 1'b1;
      sum   <= load_sum;
      cout  <= load_cout;
`ifdef SERIAL_SUM_OVF_EN
      ovf   <= load_ovf;
`endif
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Collects the LSB-first sum/carry bits of the bit-serial adder into a
// parallel word and presents it through a one-deep valid/ready buffer.
// Optional feature macro: SERIAL_SUM_OVF_EN adds res_ovf (two's-complement
// overflow of the word, carry into MSB XOR carry out of MSB).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   bit_valid            : sum_bit/carry_bit present this cycle
//   first_bit            : marks the LSB of a new word (with bit_valid)
//   sum_bit, carry_bit   : serial sum bit and carry-out of that position
//   in_ready             : a bit is accepted when bit_valid && in_ready
//   res_valid/res_ready  : output handshake, transfer when both high at an edge
//   res_sum, res_cout    : assembled word and final carry-out
//   res_ovf              : overflow flag (SERIAL_SUM_OVF_EN only)
//   frame_err            : one-cycle pulse, registered, after a framing error
module serial_sum_collector
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             first_bit,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             frame_err
`ifdef SERIAL_SUM_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] shreg;
  logic             held_cout;

  logic             accept, last_bit, word_done, slot_free;
  logic [WIDTH-1:0] next_word;
  logic             load, load_cout, frame_err_d;
  logic [WIDTH-1:0] load_sum;
`ifdef SERIAL_SUM_OVF_EN
  logic             prev_carry, held_ovf, load_ovf;
`endif

  assign accept    = bit_valid && in_ready;
  assign next_word = {sum_bit, shreg[WIDTH-1:1]};
  // A first_bit on the final position is a restart, never a completion.
  assign last_bit  = (state == COLLECT) && !first_bit
                     && (count == CNT_W'(WIDTH - 1));
  assign word_done = accept && last_bit;
  // The output slot is free if empty or being drained at this edge.
  assign slot_free = !res_valid || res_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && first_bit) state_nx = COLLECT;
      COLLECT: if (word_done)           state_nx = slot_free ? IDLE : FULL;
      FULL:    if (res_ready)           state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    in_ready    = (state != FULL);
    frame_err_d = 1'b0;
    load        = 1'b0;
    load_sum    = next_word;
    load_cout   = carry_bit;
`ifdef SERIAL_SUM_OVF_EN
    load_ovf    = prev_carry ^ carry_bit;
`endif
    case (state)
      IDLE:    frame_err_d = accept && !first_bit;
      COLLECT: begin
        frame_err_d = accept && first_bit;
        load        = word_done && slot_free;
      end
      FULL: begin
        // The completed word parked in shreg moves to the output on drain.
        load      = res_ready;
        load_sum  = shreg;
        load_cout = held_cout;
`ifdef SERIAL_SUM_OVF_EN
        load_ovf  = held_ovf;
`endif
      end
      default: ;
    endcase
  end

  // Counter, shift register and parked-word side bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      shreg      <= '0;
      held_cout  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SERIAL_SUM_OVF_EN
      prev_carry <= 1'b0;
      held_ovf   <= 1'b0;
`endif
    end else begin
      frame_err <= frame_err_d;
      // Bits without first_bit in IDLE are dropped.
      if (accept && (first_bit || state == COLLECT)) begin
        shreg <= next_word;
        count <= first_bit ? CNT_W'(1) : count + CNT_W'(1);
`ifdef SERIAL_SUM_OVF_EN
        prev_carry <= carry_bit;
`endif
      end
      if (word_done) begin
        held_cout <= carry_bit;
`ifdef SERIAL_SUM_OVF_EN
        held_ovf  <= prev_carry ^ carry_bit;
`endif
      end
    end
  end

  serial_sum_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_sum  (load_sum),
    .load_cout (load_cout),
`ifdef SERIAL_SUM_OVF_EN
    .load_ovf  (load_ovf),
    .ovf       (res_ovf),
`endif
    .ready     (res_ready),
    .valid     (res_valid),
    .sum       (res_sum),
    .cout      (res_cout)
  );

endmodule

// File: tb/tb_serial_sum_collector.sv
`timescale 1ns/1ps
module tb_serial_sum_collector;
  localparam int WIDTH = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             bit_valid = 1'b0, first_bit = 1'b0;
  logic             sum_bit = 1'b0, carry_bit = 1'b0, res_ready = 1'b0;
  logic             in_ready, res_valid, res_cout, frame_err;
  logic [WIDTH-1:0] res_sum;
`ifdef SERIAL_SUM_OVF_EN
  logic             res_ovf;
`endif

  serial_sum_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_valid (bit_valid),
    .first_bit (first_bit),
    .sum_bit   (sum_bit),
    .carry_bit (carry_bit),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .frame_err (frame_err)
`ifdef SERIAL_SUM_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words awaiting delivery ({ovf, cout, sum}), front is
  // the one on the output; the partial word as plain bit lists.
  logic [WIDTH+1:0] exp_q[$];
  logic             part_s[$];
  logic             part_c[$];
  logic             exp_ferr = 1'b0;
  logic             last_acc = 1'b0;
  logic             mon_en   = 1'b0;

  // Sum bits and per-position carries of a+b by plain arithmetic.
  function automatic void mk_word(input int a, input int b,
                                  output logic [WIDTH-1:0] s,
                                  output logic [WIDTH-1:0] c);
    for (int i = 0; i < WIDTH; i++) begin
      int m;
      m = (1 << (i + 1)) - 1;
      c[i] = (((a & m) + (b & m)) >> (i + 1)) & 1;
    end
    s = WIDTH'(a + b);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    part_s.delete();
    part_c.delete();
    exp_ferr = 1'b0;
    last_acc = 1'b0;
  endtask

  // One clock: model advances at the edge from the pre-edge inputs, then
  // control returns 1ns later so the caller can drive new inputs.
  task automatic tick();
    logic             acc, xfer;
    logic [WIDTH+1:0] w;
    @(posedge clk);
    if (rst_n) begin
      acc      = bit_valid && (exp_q.size() < 2);
      xfer     = res_ready && (exp_q.size() > 0);
      last_acc = acc;
      exp_ferr = 1'b0;
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        if (first_bit) begin
          if (part_s.size() > 0) exp_ferr = 1'b1;
          part_s.delete();
          part_c.delete();
          part_s.push_back(sum_bit);
          part_c.push_back(carry_bit);
        end else if (part_s.size() == 0) begin
          exp_ferr = 1'b1;
        end else begin
          part_s.push_back(sum_bit);
          part_c.push_back(carry_bit);
          if (part_s.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) w[i] = part_s[i];
            w[WIDTH]   = part_c[WIDTH-1];
            w[WIDTH+1] = part_c[WIDTH-2] ^ part_c[WIDTH-1];
            exp_q.push_back(w);
            part_s.delete();
            part_c.delete();
          end
        end
      end
    end else begin
      last_acc = 1'b0;
    end
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [WIDTH+1:0] f;
    if (mon_en) begin
      f = (exp_q.size() > 0) ? exp_q[0] : '0;
      n_checks++;
      if (res_valid !== (exp_q.size() > 0))
        $display("FAIL mon_valid: got %b want %b", res_valid, exp_q.size() > 0);
      else n_pass++;
      n_checks++;
      if (in_ready !== (exp_q.size() < 2))
        $display("FAIL mon_in_ready: got %b want %b", in_ready, exp_q.size() < 2);
      else n_pass++;
      n_checks++;
      if (frame_err !== exp_ferr)
        $display("FAIL mon_frame_err: got %b want %b", frame_err, exp_ferr);
      else n_pass++;
      if (exp_q.size() > 0) begin
        n_checks++;
        if ({res_cout, res_sum} !== f[WIDTH:0])
          $display("FAIL mon_word: got %h want %h", {res_cout, res_sum}, f[WIDTH:0]);
        else n_pass++;
`ifdef SERIAL_SUM_OVF_EN
        n_checks++;
        if (res_ovf !== f[WIDTH+1])
          $display("FAIL mon_ovf: got %b want %b", res_ovf, f[WIDTH+1]);
        else n_pass++;
`endif
      end
    end
  end

  // Driver tasks
  task automatic send_bit(input logic f, input logic s, input logic c);
    int tries = 0;
    bit_valid = 1'b1; first_bit = f; sum_bit = s; carry_bit = c;
    tick();
    while (!last_acc && tries < 50) begin
      tick();
      tries++;
    end
    if (!last_acc) begin
      n_checks++;
      $display("FAIL send_timeout: bit not accepted after %0d cycles, want accept", tries);
    end
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input int a, input int b);
    logic [WIDTH-1:0] s, c;
    mk_word(a, b, s, c);
    for (int i = 0; i < WIDTH; i++) send_bit(i == 0, s[i], c[i]);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({res_valid, res_sum, res_cout, frame_err, in_ready} !== {1'b0, {WIDTH{1'b0}}, 3'b001})
      $display("FAIL %s: got v=%b s=%h c=%b fe=%b ir=%b want 0 0 0 0 1",
               tag, res_valid, res_sum, res_cout, frame_err, in_ready);
    else n_pass++;
`ifdef SERIAL_SUM_OVF_EN
    n_checks++;
    if (res_ovf !== 1'b0) $display("FAIL %s_ovf: got %b want 0", tag, res_ovf);
    else n_pass++;
`endif
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({res_valid, res_sum, res_cout, frame_err, in_ready} !== {1'b0, {WIDTH{1'b0}}, 3'b001})
      $display("FAIL reset_init: got v=%b s=%h c=%b fe=%b ir=%b want 0 0 0 0 1",
               res_valid, res_sum, res_cout, frame_err, in_ready);
    else n_pass++;
    clear_model();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_known();
    res_ready = 1'b1;
    send_word(5, 6);
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_cout, res_sum} !== {2'b10, 4'b1011})
      $display("FAIL known_5p6: got v=%b c=%b s=%b want v=1 c=0 s=1011", res_valid, res_cout, res_sum);
    else n_pass++;
`ifdef SERIAL_SUM_OVF_EN
    n_checks++;
    if (res_ovf !== 1'b1) $display("FAIL known_5p6_ovf: got %b want 1", res_ovf);
    else n_pass++;
`endif
    send_word(9, 8);
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_cout, res_sum} !== {2'b11, 4'b0001})
      $display("FAIL known_9p8: got v=%b c=%b s=%b want v=1 c=1 s=0001", res_valid, res_cout, res_sum);
    else n_pass++;
`ifdef SERIAL_SUM_OVF_EN
    n_checks++;
    if (res_ovf !== 1'b1) $display("FAIL known_9p8_ovf: got %b want 1", res_ovf);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    int a1, b1, a2, b2;
    logic [WIDTH-1:0] s1, c1, s2, c2;
    a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
    a2 = $urandom_range(0, 15); b2 = $urandom_range(0, 15);
    mk_word(a1, b1, s1, c1);
    mk_word(a2, b2, s2, c2);
    res_ready = 1'b0;
    send_word(a1, b1);
    send_word(a2, b2);
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({in_ready, res_valid, res_cout, res_sum} !== {2'b01, c1[WIDTH-1], s1})
      $display("FAIL b2b_full: got ir=%b v=%b c=%b s=%h want ir=0 v=1 c=%b s=%h",
               in_ready, res_valid, res_cout, res_sum, c1[WIDTH-1], s1);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_cout, res_sum} !== {1'b1, c2[WIDTH-1], s2})
      $display("FAIL b2b_second: got v=%b c=%b s=%h want v=1 c=%b s=%h",
               res_valid, res_cout, res_sum, c2[WIDTH-1], s2);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [WIDTH-1:0] s1, c1, s2, c2;
    mk_word($urandom_range(0, 15), $urandom_range(0, 15), s1, c1);
    mk_word($urandom_range(0, 15), $urandom_range(0, 15), s2, c2);
    res_ready = 1'b1;
    send_bit(1'b1, s1[0], c1[0]);
    send_bit(1'b0, s1[1], c1[1]);
    send_bit(1'b1, s2[0], c2[0]);
    @(negedge clk);
    n_checks++;
    if (frame_err !== 1'b1) $display("FAIL ferr_restart: got %b want 1", frame_err);
    else n_pass++;
    for (int i = 1; i < WIDTH; i++) send_bit(1'b0, s2[i], c2[i]);
    @(negedge clk);
    n_checks++;
    if ({frame_err, res_valid, res_sum} !== {2'b01, s2})
      $display("FAIL ferr_word: got fe=%b v=%b s=%h want fe=0 v=1 s=%h", frame_err, res_valid, res_sum, s2);
    else n_pass++;
    tick();
  endtask

  task automatic test_no_first();
    logic [WIDTH-1:0] s, c;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      n_checks++;
      if ({frame_err, res_valid} !== 2'b10)
        $display("FAIL nofirst_%0d: got fe=%b v=%b want fe=1 v=0", i, frame_err, res_valid);
      else n_pass++;
    end
    mk_word(5, 6, s, c);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(i == 0, s[i], c[i]);
      if (i < WIDTH - 1) repeat ($urandom_range(1, 3)) tick();
    end
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_sum} !== {1'b1, 4'b1011})
      $display("FAIL gaps_word: got v=%b s=%b want v=1 s=1011", res_valid, res_sum);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1);
    do_reset("reset_midword");
    send_word(5, 6);
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_sum} !== {1'b1, 4'b1011})
      $display("FAIL after_reset_mid: got v=%b s=%b want v=1 s=1011", res_valid, res_sum);
    else n_pass++;
    tick();
    res_ready = 1'b0;
    send_word($urandom_range(0, 15), $urandom_range(0, 15));
    send_word($urandom_range(0, 15), $urandom_range(0, 15));
    tick();
    do_reset("reset_full");
    res_ready = 1'b1;
    send_word(9, 8);
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_cout, res_sum} !== {2'b11, 4'b0001})
      $display("FAIL after_reset_full: got v=%b c=%b s=%b want v=1 c=1 s=0001", res_valid, res_cout, res_sum);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int pos = 0;
    logic [WIDTH-1:0] s = '0, c = '0;
    for (int n = 0; n < 600; n++) begin
      if (pos == 0) mk_word($urandom_range(0, 15), $urandom_range(0, 15), s, c);
      bit_valid = ($urandom_range(0, 3) != 0);
      first_bit = (pos == 0);
      if ($urandom_range(0, 19) == 0) first_bit = ~first_bit;
      sum_bit   = s[pos];
      carry_bit = c[pos];
      res_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_acc) begin
        pos = first_bit ? 1 : ((pos == 0) ? 0 : pos + 1);
        if (pos == WIDTH) pos = 0;
      end
    end
    bit_valid = 1'b0;
    res_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  initial begin
    test_reset();
    test_known();
    test_back_to_back();
    test_frame_err();
    test_no_first();
    test_reset_mid();
    test_random();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_sum_collector.md
Name: serial_sum_collector

Overview:
- Downstream stage of the bit-serial adder.
- Consumes the per-cycle sum bit and carry-out bit, LSB first.
- Reassembles each WIDTH-bit result and the final carry-out into a parallel word.
- Presents the word on a valid/ready output with one-deep output buffering; applies backpressure to the serial stage when the buffer cannot drain.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- bit_valid  input  1  sum_bit/carry_bit valid this cycle
- first_bit  input  1  qualifies the LSB of a new word; sampled only with bit_valid
- sum_bit  input  1  serial sum bit, LSB first
- carry_bit  input  1  carry-out of the current bit position
- in_ready  output  1  collector accepts a bit this cycle
- res_valid  output  1  parallel result held
- res_ready  input  1  consumer takes the result
- res_sum  output  WIDTH  assembled sum
- res_cout  output  1  carry-out of the MSB position
- frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit count=0, shift register=0.
  - res_valid=0, res_sum=0, res_cout=0, frame_err=0, in_ready=1.
- Bit acceptance: a bit is accepted when bit_valid && in_ready.
- Shift rule: shreg <= {sum_bit, shreg[WIDTH-1:1]}, so after WIDTH bits shreg[0] holds the LSB.
- States:
  - IDLE: in_ready=1.
    - Accepted bit with first_bit=1: shift it in, count=1, go to COLLECT.
    - Accepted bit with first_bit=0: bit dropped, frame_err pulses.
  - COLLECT: in_ready=1.
    - Each accepted bit shifts in and increments count.
    - Accepted bit with first_bit=1 mid-word: current partial word discarded, frame_err pulses, bit taken as LSB of a new word, count=1.
  - Completion: on acceptance of the WIDTH-th bit, capture carry_bit as cout.
    - If output slot free (res_valid=0, or res_valid=1 && res_ready=1 this cycle): load res_sum/res_cout at this edge, res_valid=1 next cycle, go to IDLE.
    - Otherwise go to FULL.
  - FULL: in_ready=0; completed word held internally.
    - When res_ready=1 (res_valid is necessarily 1): load the held word into the output at that edge, res_valid stays 1, go to IDLE.
- Latency: res_valid rises one cycle after the last bit is accepted when the slot is free.
- Output handshake:
  - res_sum/res_cout stable while res_valid=1 && res_ready=0.
  - res_valid clears after a transfer unless a new word loads in the same edge (back-to-back, no bubble).
- Simultaneous events:
  - Drain and load in the same cycle: load wins and res_valid stays 1.
  - first_bit on the WIDTH-th position of a word is treated as the mid-word restart case.
- bit_valid=0 cycles anywhere: no state change (gaps allowed).
- Reset mid-word or in FULL: partial/held data lost, no res_valid, no frame_err.

Optional Feature:
- Macro SERIAL_SUM_OVF_EN.
- Defined:
  - Extra output res_ovf (1 bit, reset 0), loaded with res_sum: two's-complement overflow = (carry_bit of bit WIDTH-2) XOR (carry_bit of bit WIDTH-1).
  - Requires a one-bit register tracking the previous accepted carry.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE, COLLECT, FULL}
  - default WIDTH constant
  - localparam helper for counter width
- One natural sub-module: serial_sum_outbuf, the one-deep valid/ready output register with load/drain logic. The FSM, counter and shift register stay in the top.

Test Plan:
- WIDTH=4, bits of 5+6 (sum 1,1,0,1; carries 0,0,1,0), first_bit on bit 0, res_ready=1 -> res_valid one cycle after the 4th bit, res_sum=4'b1011, res_cout=0; with SERIAL_SUM_OVF_EN res_ovf=1.
- 9+8 (sum 1,0,0,0; carries 0,0,0,1) -> res_sum=4'b0001, res_cout=1, res_ovf=1.
- Two back-to-back words with res_ready=0 until the second completes -> in_ready=0 in FULL; first word stable; releasing res_ready yields first then second word, no loss, no bubble.
- first_bit reasserted after 2 bits -> frame_err one-cycle pulse; only the restarted word appears on res_sum.
- Bits without first_bit in IDLE -> frame_err pulses per bit, res_valid stays 0; bit_valid gaps mid-word -> result unchanged.
- rst_n low mid-word and in FULL -> all outputs return to reset values immediately (async); next well-framed word produces the correct result.
